// File: rtl/mux_nto1_rr_pkg.sv
// Shared definitions for the N:1 registered multiplexer family.
// Select-mode encodings and a width helper that never returns zero.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index; a 2-channel mux still needs one select bit
  function automatic int selw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after ptr and wraps to ptr itself.
// Requests are rotated through a double-width copy, then priority encoded.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = selw(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt,
  output logic            gnt_v
);

  logic [2*NCH-1:0] req_dbl;
  logic [NCH-1:0]   rot;
  int               base;
  int               idx;
  int               sum;

  // rot[k] is the request from channel (base + k) mod NCH, so the lowest set bit wins
  always_comb begin
    req_dbl = {req, req};
    base    = (int'(ptr) >= NCH - 1) ? 0 : int'(ptr) + 1;
    rot     = NCH'(req_dbl >> base);
    idx     = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rot[k]) idx = k;
    end
    sum = base + idx;
    if (sum >= NCH) sum = sum - NCH;
    gnt   = SELW'(sum);
    gnt_v = |req;
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-channel valid/ready multiplexer with fixed or round-robin selection
// and a single registered output stage that drains and reloads in one cycle.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = selw(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  rr_gnt;
  logic             rr_v;
  logic             fix_v;
  logic [SELW-1:0]  gnt;
  logic             gnt_v;
  logic             accept;
  logic [WIDTH-1:0] gnt_data;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .gnt   (rr_gnt),
    .gnt_v (rr_v)
  );

  // A select value at or beyond NCH matches no channel, so it never grants
  always_comb begin
    fix_v = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i) && in_valid[i]) fix_v = 1'b1;
    end
  end

  always_comb begin
    accept = !out_valid || out_ready;
    if (mode == MODE_RR) begin
      gnt   = rr_gnt;
      gnt_v = rr_v;
    end else begin
      gnt   = sel;
      gnt_v = fix_v;
    end
  end

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt == SELW'(i)) begin
        in_ready[i] = accept && gnt_v;
        gnt_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only round-robin transfers move the pointer, so it survives detours into fixed mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(NCH - 1);
    end else if (accept) begin
      if (gnt_v) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt;
        if (mode == MODE_RR) ptr <= gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: a 4-channel instance for the main scenarios
// and a 3-channel instance for out-of-range select and non-power-of-two wrap.
module tb_mux_nto1_rr;
  import mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_ch3;

  int checkCount = 0;
  int errorCount = 0;
  int inCount    = 0;
  int outCount   = 0;
  logic [7:0] sbQueue[$];

  logic [7:0] chData [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};
  logic [7:0] chData3[3] = '{8'h31, 8'h32, 8'h33};

  mux_nto1_rr #(.WIDTH(8), .NCH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  mux_nto1_rr #(.WIDTH(8), .NCH(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_ch    (out_ch3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard samples on the falling edge, where the next rising edge's handshakes are already settled
  always @(negedge clk) begin
    if (rst) begin
      sbQueue.delete();
    end else begin
      if (out_valid && out_ready) begin
        outCount++;
        if (sbQueue.size() == 0) begin
          checkOutput("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          checkOutput("sb_data", 32'(out_data), 32'(sbQueue.pop_front()));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          inCount++;
          sbQueue.push_back(chData[i]);
        end
      end
    end
  end

  initial begin
    in_data    = {chData[3], chData[2], chData[1], chData[0]};
    in_data3   = {chData3[2], chData3[1], chData3[0]};
    applyStimulus(MODE_FIXED, 2'd0, 4'b0000, 1'b1);
    mode3      = MODE_FIXED;
    sel3       = 2'd0;
    in_valid3  = 3'b000;
    out_ready3 = 1'b1;

    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Idle: nothing valid means nothing ready, in either mode
    #1 checkOutput("idle_fixed_ready", 32'(in_ready), 32'd0);
    mode = MODE_RR;
    #1 checkOutput("idle_rr_ready", 32'(in_ready), 32'd0);

    // Fixed select of channel 2 while every channel is valid
    applyStimulus(MODE_FIXED, 2'd2, 4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("fixed_in_ready", 32'(in_ready), 32'b0100);
      tick();
      checkOutput("fixed_out_valid", 32'(out_valid), 32'd1);
      checkOutput("fixed_out_data", 32'(out_data), 32'hA5);
      checkOutput("fixed_out_ch", 32'(out_ch), 32'd2);
    end
    in_valid = 4'b0000;
    tick();
    checkOutput("fixed_drain_valid", 32'(out_valid), 32'd0);

    // Round-robin with all channels valid starts at channel 0 and rotates
    applyStimulus(MODE_RR, 2'd0, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1 checkOutput("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
      tick();
      checkOutput("rr_out_ch", 32'(out_ch), 32'(i % 4));
      checkOutput("rr_out_valid", 32'(out_valid), 32'd1);
      checkOutput("rr_out_data", 32'(out_data), 32'(chData[i % 4]));
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rr_sparse_ch", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Backpressure: channel 3's word must sit still while the consumer stalls
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_out_ch", 32'(out_ch), 32'd3);
      checkOutput("stall_out_data", 32'(out_data), 32'h44);
    end
    out_ready = 1'b1;
    #1 checkOutput("release_in_ready", 32'(in_ready), 32'b0010);
    tick();
    checkOutput("release_out_ch", 32'(out_ch), 32'd1);
    checkOutput("release_out_data", 32'(out_data), 32'h22);
    in_valid = 4'b0000;
    tick();
    checkOutput("release_drain_valid", 32'(out_valid), 32'd0);
    #6 checkOutput("sb_word_count", 32'(outCount), 32'(inCount));
    checkOutput("sb_queue_empty", 32'(sbQueue.size()), 32'd0);
    tick();

    // Pointer was left at 1; two fixed-mode words must not disturb it
    applyStimulus(MODE_FIXED, 2'd0, 4'b1111, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1 checkOutput("switch_fixed_ready", 32'(in_ready), 32'b0001);
      tick();
      checkOutput("switch_fixed_ch", 32'(out_ch), 32'd0);
    end
    mode = MODE_RR;
    #1 checkOutput("switch_rr_ready", 32'(in_ready), 32'b0100);
    tick();
    checkOutput("switch_rr_ch", 32'(out_ch), 32'd2);
    checkOutput("switch_rr_data", 32'(out_data), 32'hA5);

    // Reset while a word is held discards it at once
    applyStimulus(MODE_RR, 2'd0, 4'b0000, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    checkOutput("midrst_out_ch", 32'(out_ch), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Three-channel instance: a select of 3 names no channel
    mode3     = MODE_FIXED;
    sel3      = 2'd1;
    in_valid3 = 3'b111;
    #1 checkOutput("n3_sel1_ready", 32'(in_ready3), 32'b010);
    tick();
    checkOutput("n3_sel1_ch", 32'(out_ch3), 32'd1);
    checkOutput("n3_sel1_data", 32'(out_data3), 32'h32);
    sel3 = 2'd3;
    #1 checkOutput("n3_oor_ready", 32'(in_ready3), 32'd0);
    tick();
    checkOutput("n3_oor_valid", 32'(out_valid3), 32'd0);
    checkOutput("n3_oor_ch_hold", 32'(out_ch3), 32'd1);

    // Round-robin over three channels wraps from 2 back to 0
    mode3 = MODE_RR;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("n3_rr_ch", 32'(out_ch3), 32'(i % 3));
      checkOutput("n3_rr_data", 32'(out_data3), 32'(chData3[i % 3]));
    end
    in_valid3 = 3'b000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
